// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-ported memory bus between the instruction
// fetch master (read-only) and the load/store master (read/write, byte strobes).
// One transaction is outstanding at a time; ties alternate round-robin; a hung
// slave is turned into a bus error after TIMEOUT cycles without a response.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req_*  / if_rsp_*       fetch request (valid/ready/addr) and response
//   lsu_req_* / lsu_rsp_*      LSU request (valid/ready/addr/we/wdata/wstrb) and response
//   mem_req_*                  forwarded request to memory (combinational mux)
//   mem_rsp_*                  memory response (valid/rdata/err)
//   *_rsp_* outputs are registered; mem_req_* and *_req_ready are combinational.
module bus_arbiter #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [AW-1:0]       if_req_addr,
   output logic                if_rsp_valid,
   output logic [XLEN-1:0]     if_rsp_rdata,
   output logic                if_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [AW-1:0]       lsu_req_addr,
   input  logic                lsu_req_we,
   input  logic [XLEN-1:0]     lsu_req_wdata,
   input  logic [XLEN/8-1:0]   lsu_req_wstrb,
   output logic                lsu_rsp_valid,
   output logic [XLEN-1:0]     lsu_rsp_rdata,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [AW-1:0]       mem_req_addr,
   output logic                mem_req_we,
   output logic [XLEN-1:0]     mem_req_wdata,
   output logic [XLEN/8-1:0]   mem_req_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rsp_rdata,
   input  logic                mem_rsp_err
);

   localparam int unsigned SW = XLEN / 8;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic M_IF  = 1'b0;
   localparam logic M_LSU = 1'b1;

   // Last WAIT cycle before the timeout fires (counter starts at 0 on entry).
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [0:0]      state_q, state_d;
   logic            lock_q, lock_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            if_rsp_valid_q, if_rsp_valid_d;
   logic [XLEN-1:0] if_rsp_rdata_q, if_rsp_rdata_d;
   logic            if_rsp_err_q, if_rsp_err_d;
   logic            lsu_rsp_valid_q, lsu_rsp_valid_d;
   logic [XLEN-1:0] lsu_rsp_rdata_q, lsu_rsp_rdata_d;
   logic            lsu_rsp_err_q, lsu_rsp_err_d;

   logic            idle;
   logic            winner;
   logic            win_valid;
   logic            timeout;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   // Winner selection: a locked grant overrides round-robin.
   always_comb begin
      idle = (state_q == S_IDLE);
      if (lock_q) begin
         winner = owner_q;
      end else if (if_req_valid && lsu_req_valid) begin
         winner = ~last_q;
      end else if (lsu_req_valid) begin
         winner = M_LSU;
      end else begin
         winner = M_IF;
      end
      win_valid = (winner == M_LSU) ? lsu_req_valid : if_req_valid;
   end

   // Forward the winner's request; fetches never write.
   always_comb begin
      mem_req_valid = idle && win_valid;
      if_req_ready  = idle && (winner == M_IF)  && mem_req_ready;
      lsu_req_ready = idle && (winner == M_LSU) && mem_req_ready;
      if (winner == M_LSU) begin
         mem_req_addr  = lsu_req_addr;
         mem_req_we    = lsu_req_we;
         mem_req_wdata = lsu_req_wdata;
         mem_req_wstrb = lsu_req_wstrb;
      end else begin
         mem_req_addr  = if_req_addr;
         mem_req_we    = 1'b0;
         mem_req_wdata = '0;
         mem_req_wstrb = SW'(0);
      end
   end

   // Next-state logic; a real response beats a coincident timeout.
   always_comb begin
      state_d         = state_q;
      lock_d          = lock_q;
      owner_d         = owner_q;
      last_d          = last_q;
      cnt_d           = cnt_q;
      if_rsp_valid_d  = 1'b0;
      if_rsp_rdata_d  = if_rsp_rdata_q;
      if_rsp_err_d    = if_rsp_err_q;
      lsu_rsp_valid_d = 1'b0;
      lsu_rsp_rdata_d = lsu_rsp_rdata_q;
      lsu_rsp_err_d   = lsu_rsp_err_q;
      timeout         = (cnt_q == CNT_LAST);
      rsp_rdata       = mem_rsp_valid ? mem_rsp_rdata : '0;
      rsp_err         = mem_rsp_valid ? mem_rsp_err : 1'b1;

      case (state_q)
         S_IDLE: begin
            if (mem_req_valid) begin
               owner_d = winner;
               if (mem_req_ready) begin
                  last_d  = winner;
                  lock_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  lock_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_rsp_valid || timeout) begin
               state_d = S_IDLE;
               if (owner_q == M_LSU) begin
                  lsu_rsp_valid_d = 1'b1;
                  lsu_rsp_rdata_d = rsp_rdata;
                  lsu_rsp_err_d   = rsp_err;
               end else begin
                  if_rsp_valid_d = 1'b1;
                  if_rsp_rdata_d = rsp_rdata;
                  if_rsp_err_d   = rsp_err;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         lock_q          <= 1'b0;
         owner_q         <= M_IF;
         last_q          <= M_LSU;
         cnt_q           <= '0;
         if_rsp_valid_q  <= 1'b0;
         if_rsp_rdata_q  <= '0;
         if_rsp_err_q    <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;
         lsu_rsp_rdata_q <= '0;
         lsu_rsp_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         lock_q          <= lock_d;
         owner_q         <= owner_d;
         last_q          <= last_d;
         cnt_q           <= cnt_d;
         if_rsp_valid_q  <= if_rsp_valid_d;
         if_rsp_rdata_q  <= if_rsp_rdata_d;
         if_rsp_err_q    <= if_rsp_err_d;
         lsu_rsp_valid_q <= lsu_rsp_valid_d;
         lsu_rsp_rdata_q <= lsu_rsp_rdata_d;
         lsu_rsp_err_q   <= lsu_rsp_err_d;
      end
   end

   assign if_rsp_valid  = if_rsp_valid_q;
   assign if_rsp_rdata  = if_rsp_rdata_q;
   assign if_rsp_err    = if_rsp_err_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign lsu_rsp_rdata = lsu_rsp_rdata_q;
   assign lsu_rsp_err   = lsu_rsp_err_q;

endmodule
